// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the magnitude divider front end.
//   DIV_DW      : operand / result width (16).
//   DIV_CW      : width of the iteration counter, wide enough to hold DIV_DW.
//   div_state_t : divider control states (IDLE, ITER, DONE).
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_CW = $clog2(DIV_DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : div_pkg

// File: rtl/div_abs.sv
// -----------------------------------------------------------------------------
// div_abs
// Combinational sign / magnitude extraction of a two's-complement value.
// Ports:
//   x_i    : W-bit two's-complement input.
//   sign_o : MSB of x_i.
//   mag_o  : unsigned W-bit magnitude. The most negative value maps onto
//            itself (e.g. 16'h8000), which is its correct unsigned magnitude.
// -----------------------------------------------------------------------------
module div_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  output logic         sign_o,
  output logic [W-1:0] mag_o
);

  assign sign_o = x_i[W-1];
  assign mag_o  = x_i[W-1] ? ((~x_i) + {{(W-1){1'b0}}, 1'b1}) : x_i;

endmodule : div_abs

// File: rtl/div_magnitude_core.sv
// -----------------------------------------------------------------------------
// div_magnitude_core
// Signed-operand front end plus unsigned restoring divider. Produces the raw
// quotient and remainder magnitudes and the operand signs; sign correction is
// done by a downstream stage.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor skips the iterations (IDLE -> DONE directly),
//               Result_RAW = all ones, Residue_RAW = |dividend|,
//               div_by_zero = 1.
//   undefined : a zero divisor runs all DW iterations (which naturally yield
//               all ones / |dividend|) and div_by_zero is tied to 0.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset.
//   start          : division request, accepted only while ready = 1.
//   dividend       : DW-bit two's-complement dividend.
//   divisor        : DW-bit two's-complement divisor.
//   ready          : idle, will accept start.
//   done           : one-cycle pulse, result outputs valid from this cycle on.
//   Dividend_Sign  : captured dividend MSB.
//   Divisor_Sign   : captured divisor MSB.
//   Result_RAW     : unsigned quotient magnitude.
//   Residue_RAW    : unsigned remainder magnitude.
//   div_by_zero    : divisor was zero (valid with done).
// -----------------------------------------------------------------------------
module div_magnitude_core
  import div_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic          Dividend_Sign,
  output logic          Divisor_Sign,
  output logic [DW-1:0] Result_RAW,
  output logic [DW-1:0] Residue_RAW,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  // ---------------------------------------------------------------------------
  // Operand sign/magnitude extraction: index 0 = dividend, 1 = divisor
  // ---------------------------------------------------------------------------
  logic [1:0][DW-1:0] op_raw;
  logic [1:0]         op_sign;
  logic [1:0][DW-1:0] op_mag;

  assign op_raw[0] = dividend;
  assign op_raw[1] = divisor;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      div_abs #(
        .W(DW)
      ) u_abs (
        .x_i    (op_raw[gi]),
        .sign_o (op_sign[gi]),
        .mag_o  (op_mag[gi])
      );
    end
  endgenerate

`ifdef DIV_ZERO_DETECT_EN
  logic divisor_zero;
  assign divisor_zero = (op_mag[1] == '0);
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   dvsr_q, dvsr_d;
  logic            dvd_sign_q, dvd_sign_d;
  logic            dvs_sign_q, dvs_sign_d;
  logic [DW-1:0]   result_q, result_d;
  logic [DW-1:0]   residue_q, residue_d;
`ifdef DIV_ZERO_DETECT_EN
  logic            dbz_q, dbz_d;
`endif

  logic last_iter;
  assign last_iter = (cnt_q == CW'(1));

  // ---------------------------------------------------------------------------
  // One restoring step. The partial remainder is always below the divisor, so
  // the trial needs one extra bit but the accepted remainder fits in DW bits.
  // ---------------------------------------------------------------------------
  logic [DW:0]   trial;
  logic          trial_ge;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] quo_step;

  always_comb begin
    trial    = {rem_q, quo_q[DW-1]};
    trial_ge = (trial >= {1'b0, dvsr_q});
    rem_step = trial_ge ? DW'(trial - {1'b0, dvsr_q}) : trial[DW-1:0];
    quo_step = {quo_q[DW-2:0], trial_ge};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          state_d = divisor_zero ? DONE : ITER;
`else
          state_d = ITER;
`endif
        end
      end
      ITER: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    dvd_sign_d = dvd_sign_q;
    dvs_sign_d = dvs_sign_q;
    result_d   = result_q;
    residue_d  = residue_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d      = dbz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_sign_d = op_sign[0];
          dvs_sign_d = op_sign[1];
          quo_d      = op_mag[0];
          dvsr_d     = op_mag[1];
          rem_d      = '0;
          cnt_d      = CW'(DW);
`ifdef DIV_ZERO_DETECT_EN
          // Shortcut: publish the all-ones quotient immediately.
          if (divisor_zero) begin
            result_d  = '1;
            residue_d = op_mag[0];
            dbz_d     = 1'b1;
          end
`endif
        end
      end
      ITER: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        // Final step: results are published as DONE is entered.
        if (last_iter) begin
          result_d  = quo_step;
          residue_d = rem_step;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d     = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      dvd_sign_q <= 1'b0;
      dvs_sign_q <= 1'b0;
      result_q   <= '0;
      residue_q  <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      dvd_sign_q <= dvd_sign_d;
      dvs_sign_q <= dvs_sign_d;
      result_q   <= result_d;
      residue_q  <= residue_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q      <= dbz_d;
`endif
    end
  end

  assign Dividend_Sign = dvd_sign_q;
  assign Divisor_Sign  = dvs_sign_q;
  assign Result_RAW    = result_q;
  assign Residue_RAW   = residue_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero   = dbz_q;
`else
  assign div_by_zero   = 1'b0;
`endif

endmodule : div_magnitude_core

// File: tb/tb_div_magnitude_core.sv
// -----------------------------------------------------------------------------
// tb_div_magnitude_core
// Directed-vector bench for div_magnitude_core. Cycle numbering: the start
// request is sampled at edge 0; cycle N is the period following edge N-1, so a
// full division shows done in cycle 17 with ready low in cycles 1..17.
// Honors DIV_ZERO_DETECT_EN for the divide-by-zero expectations.
// -----------------------------------------------------------------------------
module tb_div_magnitude_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic        Dividend_Sign;
  logic        Divisor_Sign;
  logic [15:0] Result_RAW;
  logic [15:0] Residue_RAW;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  localparam int FULL_LAT = 17;
`ifdef DIV_ZERO_DETECT_EN
  localparam int    ZERO_LAT = 1;
  localparam logic  ZERO_DBZ = 1'b1;
`else
  localparam int    ZERO_LAT = FULL_LAT;
  localparam logic  ZERO_DBZ = 1'b0;
`endif

  always #5 clk = ~clk;

  div_magnitude_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .ready         (ready),
    .done          (done),
    .Dividend_Sign (Dividend_Sign),
    .Divisor_Sign  (Divisor_Sign),
    .Result_RAW    (Result_RAW),
    .Residue_RAW   (Residue_RAW),
    .div_by_zero   (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one division. Must be called at a sampling point (#1 after an edge)
  // with the DUT idle. inj > 0 pulses a competing start (50 / 5) in that cycle.
  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_sd, input logic exp_ss, input logic exp_dbz,
                         input int exp_lat, input int inj);
    int dcyc;
    int dcnt;
    int rbad;
    dcyc = 0;
    dcnt = 0;
    rbad = 0;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= exp_lat + 2; c++) begin
      if (done) begin
        dcnt++;
        if (dcyc == 0) dcyc = c;
      end
      if (c <= exp_lat && ready) rbad++;
      if (c > exp_lat) check($sformatf("%s_ready_c%0d", tag, c), ready, 1);
      if (c == inj) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (c < exp_lat + 2) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, dcyc, exp_lat);
    check({tag, "_done_count"}, dcnt, 1);
    check({tag, "_ready_low"}, rbad, 0);
    check({tag, "_quotient"}, Result_RAW, exp_q);
    check({tag, "_residue"}, Residue_RAW, exp_r);
    check({tag, "_dvd_sign"}, Dividend_Sign, exp_sd);
    check({tag, "_dvs_sign"}, Divisor_Sign, exp_ss);
    check({tag, "_div_by_zero"}, div_by_zero, exp_dbz);
    $display("div %s: %0d / %0d -> q=%0d r=%0d signs=%0b/%0b dbz=%0b done@%0d",
             tag, $signed(dvd), $signed(dvs), Result_RAW, Residue_RAW,
             Dividend_Sign, Divisor_Sign, div_by_zero, dcyc);
  endtask

  initial begin
    int dcnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_outputs", {Result_RAW, Residue_RAW}, 32'h0);
    check("reset_flags", {Dividend_Sign, Divisor_Sign, div_by_zero}, 0);
    $display("reset: ready=%0b done=%0b", ready, done);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("p100_p7",   16'd100,  16'd7,   16'd14,   16'd2, 1'b0, 1'b0, 1'b0, FULL_LAT, 0);
    run_div("m100_p7",   16'hFF9C, 16'd7,   16'd14,   16'd2, 1'b1, 1'b0, 1'b0, FULL_LAT, 0);
    run_div("p100_m7",   16'd100,  16'hFFF9, 16'd14,  16'd2, 1'b0, 1'b1, 1'b0, FULL_LAT, 0);
    run_div("min_m1",    16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b1, 1'b1, 1'b0, FULL_LAT, 0);
    run_div("p7_p100",   16'd7,    16'd100, 16'd0,    16'd7, 1'b0, 1'b0, 1'b0, FULL_LAT, 0);
    run_div("p5_zero",   16'd5,    16'd0,   16'hFFFF, 16'd5, 1'b0, 1'b0, ZERO_DBZ, ZERO_LAT, 0);
    run_div("p1000_p3",  16'd1000, 16'd3,   16'd333,  16'd1, 1'b0, 1'b0, 1'b0, FULL_LAT, 5);
    // Competing start lands in the DONE cycle and must be dropped.
    run_div("m1_p1",     16'hFFFF, 16'd1,   16'd1,    16'd0, 1'b1, 1'b0, 1'b0, FULL_LAT, FULL_LAT);

    // Reset in the middle of 1000 / 3.
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt  = 0;
    for (int c = 1; c < 8; c++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_outputs", {Result_RAW, Residue_RAW}, 32'h0);
    check("abort_flags", {Dividend_Sign, Divisor_Sign, div_by_zero}, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    check("abort_no_done", dcnt, 0);
    $display("abort: ready=%0b done_pulses=%0d", ready, dcnt);

    run_div("p9_p2",     16'd9,    16'd2,   16'd4,    16'd1, 1'b0, 1'b0, 1'b0, FULL_LAT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_magnitude_core
